// File: rtl/idct_2d_sched.sv
// Control scheduler for a row/column 2D IDCT built around one shared 1D IDCT and a transpose buffer.
// Optional macro IDCT_SCHED_STATS_EN adds a 16-bit completed-block counter port (blocks_done_out).
module idct_2d_sched #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       row_valid_in,
  output logic       row_ready_out,
  output logic       src_sel_out,
  output logic       issue_out,
  output logic       mtb_wr_out,
  output logic [2:0] mtb_wr_idx_out,
  output logic       mtb_rd_out,
  output logic [2:0] mtb_rd_idx_out,
  output logic       out_valid_out,
  output logic [2:0] out_idx_out,
  output logic       out_last_out,
`ifdef IDCT_SCHED_STATS_EN
  output logic [15:0] blocks_done_out,
`endif
  output logic       busy_out
);

  if (PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_bad_pipe_lat
    $error("idct_2d_sched: PIPE_LAT must be within 1..8");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("idct_2d_sched: WIDTH must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ROW     = 3'd1,
    ST_DRAIN_R = 3'd2,
    ST_COL     = 3'd3,
    ST_DRAIN_C = 3'd4
  } state_t;

  // One delay-line slot: which row/column is in flight through the 1D IDCT and on which pass.
  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
    logic       col;
  } dl_ent_t;

  localparam int unsigned ENT_W = $bits(dl_ent_t);
  localparam int unsigned DL_W  = ENT_W * PIPE_LAT;

  state_t          state_q, state_d;
  logic [2:0]      row_cnt_q, row_cnt_d;
  logic [2:0]      col_cnt_q, col_cnt_d;
  logic [DL_W-1:0] dl_q, dl_d;

  logic            row_ready_q, row_ready_d;
  logic            src_sel_q, src_sel_d;
  logic            issue_q, issue_d;
  logic            mtb_wr_q, mtb_wr_d;
  logic [2:0]      mtb_wr_idx_q, mtb_wr_idx_d;
  logic            mtb_rd_q, mtb_rd_d;
  logic [2:0]      mtb_rd_idx_q, mtb_rd_idx_d;
  logic            out_valid_q, out_valid_d;
  logic [2:0]      out_idx_q, out_idx_d;
  logic            out_last_q, out_last_d;
  logic            busy_q, busy_d;
`ifdef IDCT_SCHED_STATS_EN
  logic [15:0]     blocks_done_q, blocks_done_d;
`endif

  logic            hs_c;
  dl_ent_t         ent_c;
  dl_ent_t         tail_c;

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    col_cnt_d    = col_cnt_q;
    src_sel_d    = src_sel_q;
    issue_d      = 1'b0;
    mtb_rd_d     = 1'b0;
    mtb_rd_idx_d = 3'd0;
    ent_c        = '0;

    hs_c   = row_valid_in && row_ready_q;
    tail_c = dl_ent_t'(dl_q[DL_W-1 -: ENT_W]);

    // Results leaving the 1D pipeline: row pass goes to the buffer, column pass is final output.
    mtb_wr_d     = tail_c.valid && !tail_c.col;
    mtb_wr_idx_d = mtb_wr_d ? tail_c.idx : 3'd0;
    out_valid_d  = tail_c.valid && tail_c.col;
    out_idx_d    = out_valid_d ? tail_c.idx : 3'd0;
    out_last_d   = out_valid_d && (tail_c.idx == 3'd7);

    // Issue sources are mutually exclusive by state, so at most one fires per cycle.
    if (hs_c) begin
      issue_d   = 1'b1;
      src_sel_d = 1'b0;
      ent_c     = '{valid: 1'b1, idx: row_cnt_q, col: 1'b0};
    end
    if (mtb_rd_q) begin
      issue_d   = 1'b1;
      src_sel_d = 1'b1;
      ent_c     = '{valid: 1'b1, idx: mtb_rd_idx_q, col: 1'b1};
    end

    dl_d = DL_W'({dl_q, ent_c});

    case (state_q)
      ST_IDLE: begin
        if (hs_c) begin
          state_d   = ST_ROW;
          row_cnt_d = 3'd1;
        end
      end
      ST_ROW: begin
        if (hs_c) begin
          row_cnt_d = row_cnt_q + 3'd1;
          if (row_cnt_q == 3'd7) state_d = ST_DRAIN_R;
        end
      end
      ST_DRAIN_R: begin
        if (mtb_wr_q && (mtb_wr_idx_q == 3'd7)) begin
          state_d   = ST_COL;
          col_cnt_d = 3'd0;
        end
      end
      ST_COL: begin
        mtb_rd_d     = 1'b1;
        mtb_rd_idx_d = col_cnt_q;
        col_cnt_d    = col_cnt_q + 3'd1;
        if (col_cnt_q == 3'd7) state_d = ST_DRAIN_C;
      end
      ST_DRAIN_C: begin
        if (out_last_d) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    row_ready_d = (state_d == ST_IDLE) || (state_d == ST_ROW);
    busy_d      = (state_d != ST_IDLE);

`ifdef IDCT_SCHED_STATS_EN
    blocks_done_d = blocks_done_q + 16'(out_last_q);
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      row_cnt_q     <= 3'd0;
      col_cnt_q     <= 3'd0;
      dl_q          <= '0;
      row_ready_q   <= 1'b1;
      src_sel_q     <= 1'b0;
      issue_q       <= 1'b0;
      mtb_wr_q      <= 1'b0;
      mtb_wr_idx_q  <= 3'd0;
      mtb_rd_q      <= 1'b0;
      mtb_rd_idx_q  <= 3'd0;
      out_valid_q   <= 1'b0;
      out_idx_q     <= 3'd0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
`ifdef IDCT_SCHED_STATS_EN
      blocks_done_q <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      row_cnt_q     <= row_cnt_d;
      col_cnt_q     <= col_cnt_d;
      dl_q          <= dl_d;
      row_ready_q   <= row_ready_d;
      src_sel_q     <= src_sel_d;
      issue_q       <= issue_d;
      mtb_wr_q      <= mtb_wr_d;
      mtb_wr_idx_q  <= mtb_wr_idx_d;
      mtb_rd_q      <= mtb_rd_d;
      mtb_rd_idx_q  <= mtb_rd_idx_d;
      out_valid_q   <= out_valid_d;
      out_idx_q     <= out_idx_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
`ifdef IDCT_SCHED_STATS_EN
      blocks_done_q <= blocks_done_d;
`endif
    end
  end

  assign row_ready_out  = row_ready_q;
  assign src_sel_out    = src_sel_q;
  assign issue_out      = issue_q;
  assign mtb_wr_out     = mtb_wr_q;
  assign mtb_wr_idx_out = mtb_wr_idx_q;
  assign mtb_rd_out     = mtb_rd_q;
  assign mtb_rd_idx_out = mtb_rd_idx_q;
  assign out_valid_out  = out_valid_q;
  assign out_idx_out    = out_idx_q;
  assign out_last_out   = out_last_q;
  assign busy_out       = busy_q;
`ifdef IDCT_SCHED_STATS_EN
  assign blocks_done_out = blocks_done_q;
`endif

endmodule

// File: tb/tb_idct_2d_sched.sv
// Directed bench for idct_2d_sched: three instances with PIPE_LAT = 3, 1 and 8 share one clock.
module tb_idct_2d_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst    [3];
  logic       rv     [3];
  logic       ready  [3];
  logic       src    [3];
  logic       issue  [3];
  logic       wr     [3];
  logic [2:0] wr_idx [3];
  logic       rd     [3];
  logic [2:0] rd_idx [3];
  logic       ov     [3];
  logic [2:0] oidx   [3];
  logic       last   [3];
  logic       busy   [3];
`ifdef IDCT_SCHED_STATS_EN
  logic [15:0] bdone [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    idct_2d_sched #(
      .WIDTH   (12),
      .PIPE_LAT((g == 0) ? 3 : ((g == 1) ? 1 : 8))
    ) u_dut (
      .clk_in        (clk),
      .rst_in        (rst[g]),
      .row_valid_in  (rv[g]),
      .row_ready_out (ready[g]),
      .src_sel_out   (src[g]),
      .issue_out     (issue[g]),
      .mtb_wr_out    (wr[g]),
      .mtb_wr_idx_out(wr_idx[g]),
      .mtb_rd_out    (rd[g]),
      .mtb_rd_idx_out(rd_idx[g]),
      .out_valid_out (ov[g]),
      .out_idx_out   (oidx[g]),
      .out_last_out  (last[g]),
`ifdef IDCT_SCHED_STATS_EN
      .blocks_done_out(bdone[g]),
`endif
      .busy_out      (busy[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle capture of one instance's outputs, cycle 0 = first cycle after reset release.
  logic       lg_hs    [128];
  logic       lg_ready [128];
  logic       lg_busy  [128];
  logic       lg_issue [128];
  logic       lg_src   [128];
  logic       lg_wr    [128];
  logic [2:0] lg_wr_idx[128];
  logic       lg_rd    [128];
  logic [2:0] lg_rd_idx[128];
  logic       lg_ov    [128];
  logic [2:0] lg_oidx  [128];
  logic       lg_last  [128];

  function automatic logic [16:0] snap(input int g);
    return {ready[g], busy[g], issue[g], src[g], wr[g], wr_idx[g],
            rd[g], rd_idx[g], ov[g], oidx[g], last[g]};
  endfunction

  function automatic logic [16:0] lg_vec(input int c);
    return {lg_ready[c], lg_busy[c], lg_issue[c], lg_src[c], lg_wr[c], lg_wr_idx[c],
            lg_rd[c], lg_rd_idx[c], lg_ov[c], lg_oidx[c], lg_last[c]};
  endfunction

  task automatic apply_reset(input int g);
    @(negedge clk);
    rst[g] = 1'b1;
    rv[g]  = 1'b0;
    @(negedge clk);
  endtask

  // Offers up to max_rows rows, valid every (gap+1) cycles, held until accepted.
  task automatic run_block(input int g, input int gap, input int max_rows, input int ncyc);
    int sent;
    sent = 0;
    for (int c = 0; c < ncyc; c++) begin
      lg_ready[c] = ready[g]; lg_busy[c] = busy[g]; lg_issue[c] = issue[g];
      lg_src[c] = src[g]; lg_wr[c] = wr[g]; lg_wr_idx[c] = wr_idx[g];
      lg_rd[c] = rd[g]; lg_rd_idx[c] = rd_idx[g]; lg_ov[c] = ov[g];
      lg_oidx[c] = oidx[g]; lg_last[c] = last[g]; lg_hs[c] = 1'b0;
      rst[g] = 1'b0;
      rv[g]  = (sent < max_rows) && ((c % (gap + 1)) == 0);
      if (rv[g] && ready[g] === 1'b1) begin
        lg_hs[c] = 1'b1;
        sent++;
      end
      @(negedge clk);
    end
    rv[g] = 1'b0;
  endtask

  task automatic test_reset();
    for (int g = 0; g < 3; g++) begin
      apply_reset(g);
      n_tests++;
      if (snap(g) !== 17'h10000) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got %h want %h", g, snap(g), 17'h10000);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat_tab[3]  = '{3, 1, 8};
    int last_tab[3] = '{24, 20, 34};
    for (int g = 0; g < 3; g++) begin
      int lat, t_last, ncyc;
      logic e_wr, e_rd, e_ov;
      logic [16:0] exp_v;
      lat  = lat_tab[g];
      ncyc = 22 + 2 * lat;
      apply_reset(g);
      run_block(g, 0, 8, ncyc);
      t_last = -1;
      for (int c = 0; c < ncyc; c++) begin
        e_wr = (c >= 1 + lat) && (c <= 8 + lat);
        e_rd = (c >= 10 + lat) && (c <= 17 + lat);
        e_ov = (c >= 11 + 2 * lat) && (c <= 18 + 2 * lat);
        exp_v = {(c <= 7) || (c >= 18 + 2 * lat),
                 (c >= 1) && (c <= 17 + 2 * lat),
                 ((c >= 1) && (c <= 8)) || ((c >= 11 + lat) && (c <= 18 + lat)),
                 c >= 11 + lat,
                 e_wr, e_wr ? 3'(c - 1 - lat) : 3'd0,
                 e_rd, e_rd ? 3'(c - 10 - lat) : 3'd0,
                 e_ov, e_ov ? 3'(c - 11 - 2 * lat) : 3'd0,
                 c == 18 + 2 * lat};
        n_tests++;
        if (lg_vec(c) !== exp_v) begin
          n_fail++;
          $display("FAIL b2b_cycle dut%0d c=%0d: got %h want %h", g, c, lg_vec(c), exp_v);
        end
        if (lg_last[c] === 1'b1 && t_last < 0) t_last = c;
      end
      n_tests++;
      if (t_last !== last_tab[g]) begin
        n_fail++;
        $display("FAIL b2b_latency dut%0d: got %0d want %0d", g, t_last, last_tab[g]);
      end
    end
  endtask

  task automatic test_row_gaps();
    int n_iss, n_bad_src, n_wr, first_rd, t_last;
    apply_reset(0);
    run_block(0, 1, 8, 40);
    n_iss = 0; n_bad_src = 0; n_wr = 0; first_rd = -1; t_last = -1;
    for (int c = 0; c < 40; c++) begin
      if (c <= 18 && lg_issue[c] === 1'b1) begin
        n_iss++;
        if (lg_src[c] !== 1'b0 || (c % 2) != 1) n_bad_src++;
      end
      if (lg_wr[c] === 1'b1) begin
        n_tests++;
        if (lg_wr_idx[c] !== 3'(n_wr) || c != 4 + 2 * n_wr) begin
          n_fail++;
          $display("FAIL gap_wr: c=%0d idx %0d want idx %0d at c=%0d", c, lg_wr_idx[c], n_wr, 4 + 2 * n_wr);
        end
        n_wr++;
      end
      if (lg_rd[c] === 1'b1 && first_rd < 0) first_rd = c;
      if (lg_last[c] === 1'b1 && t_last < 0) t_last = c;
    end
    n_tests++;
    if (n_iss !== 8 || n_bad_src !== 0) begin
      n_fail++;
      $display("FAIL gap_issue: got %0d issues (%0d bad), want 8 (0 bad)", n_iss, n_bad_src);
    end
    n_tests++;
    if (n_wr !== 8) begin
      n_fail++;
      $display("FAIL gap_wr_count: got %0d want 8", n_wr);
    end
    n_tests++;
    if (first_rd !== 20) begin
      n_fail++;
      $display("FAIL gap_first_rd: got %0d want 20", first_rd);
    end
    n_tests++;
    if (t_last !== 31) begin
      n_fail++;
      $display("FAIL gap_last: got %0d want 31", t_last);
    end
  endtask

  task automatic test_held_valid();
    int hs9, n_last, last1, last2, overlap;
    apply_reset(0);
    run_block(0, 0, 16, 52);
    hs9 = -1; n_last = 0; last1 = -1; last2 = -1; overlap = 0;
    for (int c = 0; c < 52; c++) begin
      if (c >= 8 && lg_hs[c] === 1'b1 && hs9 < 0) hs9 = c;
      if (lg_last[c] === 1'b1) begin
        n_last++;
        if (last1 < 0) last1 = c; else if (last2 < 0) last2 = c;
      end
      if (c >= 9 && c <= 24 && lg_issue[c] === 1'b1 && lg_src[c] === 1'b0) overlap++;
      if (lg_rd[c] === 1'b1 && lg_wr[c] === 1'b1) overlap++;
    end
    n_tests++;
    if (hs9 !== 24 || last1 !== 24) begin
      n_fail++;
      $display("FAIL held_second_hs: hs at %0d, last at %0d, want both 24", hs9, last1);
    end
    n_tests++;
    if (last2 !== 48 || n_last !== 2) begin
      n_fail++;
      $display("FAIL held_second_last: got %0d (%0d lasts) want 48 (2)", last2, n_last);
    end
    n_tests++;
    if (overlap !== 0) begin
      n_fail++;
      $display("FAIL held_overlap: got %0d overlapping cycles want 0", overlap);
    end
  endtask

  task automatic test_mid_reset();
    int found, stray;
    apply_reset(0);
    found = -1;
    for (int c = 0; c < 40 && found < 0; c++) begin
      rst[0] = 1'b0;
      rv[0]  = (c < 8);
      if (rd[0] === 1'b1 && rd_idx[0] === 3'd3) begin
        found  = c;
        rst[0] = 1'b1;
        rv[0]  = 1'b0;
      end
      @(negedge clk);
    end
    n_tests++;
    if (found !== 16) begin
      n_fail++;
      $display("FAIL midrst_rd3_cycle: got %0d want 16", found);
    end
    n_tests++;
    if (snap(0) !== 17'h10000) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %h want %h", snap(0), 17'h10000);
    end
    rst[0] = 1'b0;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ov[0] !== 1'b0 || wr[0] !== 1'b0 || issue[0] !== 1'b0 ||
          rd[0] !== 1'b0 || busy[0] !== 1'b0) stray++;
    end
    n_tests++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL midrst_stray: got %0d active cycles want 0", stray);
    end
  endtask

  task automatic test_stats();
`ifdef IDCT_SCHED_STATS_EN
    apply_reset(0);
    n_tests++;
    if (bdone[0] !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_reset: got %0d want 0", bdone[0]);
    end
    run_block(0, 0, 24, 80);
    n_tests++;
    if (bdone[0] !== 16'd3) begin
      n_fail++;
      $display("FAIL stats_three: got %0d want 3", bdone[0]);
    end
    apply_reset(0);
    n_tests++;
    if (bdone[0] !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_clear: got %0d want 0", bdone[0]);
    end
`endif
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1;
      rv[g]  = 1'b0;
    end
    repeat (2) @(negedge clk);
    test_reset();
    test_back_to_back();
    test_row_gaps();
    test_held_valid();
    test_mid_reset();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
